// File: rtl/rv_pipe_pkg.sv
// Shared pipeline types: decoded control bundle, its NOP value and result-source encodings.
// Imported by the decode/control unit and by the execute-side pipeline registers.
package rv_pipe_pkg;

  localparam logic [1:0] RESULT_MEM = 2'b01;

  typedef struct packed {
    logic [2:0] ALUctrl;
    logic [2:0] ImmSrc;
    logic       RegWrite;
    logic       ALUSrc;
    logic       MemWrite;
    logic [1:0] ResultSrc;
    logic       Jump;
    logic       Branch;
    logic       branch_neg;
    logic       PcOp;
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '0;

endpackage

// File: rtl/hazard_detect.sv
// Load-use hazard detection: a load in EX whose destination feeds a source of the
// instruction currently in decode. Purely combinational.
module hazard_detect
  import rv_pipe_pkg::*;
(
  input  logic       valid_e,
  input  logic       reg_write_e,
  input  logic [1:0] result_src_e,
  input  logic [4:0] rd_e,
  input  logic       valid_d,
  input  logic [4:0] rs1_d,
  input  logic [4:0] rs2_d,
  output logic       load_use
);

  logic load_in_ex;
  logic src_match;

  // x0 is hard-wired zero, so a load targeting it can never create a dependency.
  assign load_in_ex = valid_e & reg_write_e & (result_src_e == RESULT_MEM) & (rd_e != 5'd0);
  assign src_match  = (rd_e == rs1_d) | (rd_e == rs2_d);
  assign load_use   = load_in_ex & src_match & valid_d;

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with flush/stall/load-use bubble priority.
// Optional macro ID_EX_PERF_EN adds saturating bubble and stall counters.
module id_ex_stage
  import rv_pipe_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        valid_d,
  input  ctrl_t       ctrl_d,
  input  logic [31:0] pc_d,
  input  logic [31:0] pc_plus4_d,
  input  logic [31:0] rd1_d,
  input  logic [31:0] rd2_d,
  input  logic [31:0] imm_d,
  input  logic [4:0]  rs1_d,
  input  logic [4:0]  rs2_d,
  input  logic [4:0]  rd_d,
  input  logic        flush_e,
  input  logic        stall_e,
  output logic        stall_d,
`ifdef ID_EX_PERF_EN
  output logic [31:0] perf_bubbles,
  output logic [31:0] perf_stalls,
`endif
  output logic        valid_e,
  output ctrl_t       ctrl_e,
  output logic [31:0] pc_e,
  output logic [31:0] pc_plus4_e,
  output logic [31:0] rd1_e,
  output logic [31:0] rd2_e,
  output logic [31:0] imm_e,
  output logic [4:0]  rs1_e,
  output logic [4:0]  rs2_e,
  output logic [4:0]  rd_e
);

  logic        valid_e_q, valid_e_d;
  ctrl_t       ctrl_e_q, ctrl_e_d;
  logic [31:0] pc_e_q, pc_e_d;
  logic [31:0] pc_plus4_e_q, pc_plus4_e_d;
  logic [31:0] rd1_e_q, rd1_e_d;
  logic [31:0] rd2_e_q, rd2_e_d;
  logic [31:0] imm_e_q, imm_e_d;
  logic [4:0]  rs1_e_q, rs1_e_d;
  logic [4:0]  rs2_e_q, rs2_e_d;
  logic [4:0]  rd_e_q, rd_e_d;
  logic        load_use;
  logic        bubble;

  hazard_detect u_hazard_detect (
    .valid_e      (valid_e_q),
    .reg_write_e  (ctrl_e_q.RegWrite),
    .result_src_e (ctrl_e_q.ResultSrc),
    .rd_e         (rd_e_q),
    .valid_d      (valid_d),
    .rs1_d        (rs1_d),
    .rs2_d        (rs2_d),
    .load_use     (load_use)
  );

  // A flush already kills the EX slot, so a pending load-use must not freeze decode.
  assign stall_d = stall_e | (load_use & ~flush_e);

  always_comb begin
    valid_e_d    = valid_e_q;
    ctrl_e_d     = ctrl_e_q;
    pc_e_d       = pc_e_q;
    pc_plus4_e_d = pc_plus4_e_q;
    rd1_e_d      = rd1_e_q;
    rd2_e_d      = rd2_e_q;
    imm_e_d      = imm_e_q;
    rs1_e_d      = rs1_e_q;
    rs2_e_d      = rs2_e_q;
    rd_e_d       = rd_e_q;
    bubble       = 1'b0;
    if (flush_e) begin
      bubble = 1'b1;
    end else if (stall_e) begin
      bubble = 1'b0;
    end else if (load_use || !valid_d) begin
      bubble = 1'b1;
    end else begin
      valid_e_d    = 1'b1;
      ctrl_e_d     = ctrl_d;
      pc_e_d       = pc_d;
      pc_plus4_e_d = pc_plus4_d;
      rd1_e_d      = rd1_d;
      rd2_e_d      = rd2_d;
      imm_e_d      = imm_d;
      rs1_e_d      = rs1_d;
      rs2_e_d      = rs2_d;
      rd_e_d       = rd_d;
    end
    // Bubbles clear only valid/control; data fields keep stale values.
    if (bubble) begin
      valid_e_d = 1'b0;
      ctrl_e_d  = CTRL_NOP;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_e_q    <= 1'b0;
      ctrl_e_q     <= CTRL_NOP;
      pc_e_q       <= '0;
      pc_plus4_e_q <= '0;
      rd1_e_q      <= '0;
      rd2_e_q      <= '0;
      imm_e_q      <= '0;
      rs1_e_q      <= '0;
      rs2_e_q      <= '0;
      rd_e_q       <= '0;
    end else begin
      valid_e_q    <= valid_e_d;
      ctrl_e_q     <= ctrl_e_d;
      pc_e_q       <= pc_e_d;
      pc_plus4_e_q <= pc_plus4_e_d;
      rd1_e_q      <= rd1_e_d;
      rd2_e_q      <= rd2_e_d;
      imm_e_q      <= imm_e_d;
      rs1_e_q      <= rs1_e_d;
      rs2_e_q      <= rs2_e_d;
      rd_e_q       <= rd_e_d;
    end
  end

  assign valid_e    = valid_e_q;
  assign ctrl_e     = ctrl_e_q;
  assign pc_e       = pc_e_q;
  assign pc_plus4_e = pc_plus4_e_q;
  assign rd1_e      = rd1_e_q;
  assign rd2_e      = rd2_e_q;
  assign imm_e      = imm_e_q;
  assign rs1_e      = rs1_e_q;
  assign rs2_e      = rs2_e_q;
  assign rd_e       = rd_e_q;

`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles_q, perf_bubbles_d;
  logic [31:0] perf_stalls_q, perf_stalls_d;

  always_comb begin
    perf_bubbles_d = perf_bubbles_q;
    perf_stalls_d  = perf_stalls_q;
    if (bubble && (perf_bubbles_q != 32'hFFFF_FFFF)) perf_bubbles_d = perf_bubbles_q + 32'd1;
    if (stall_d && (perf_stalls_q != 32'hFFFF_FFFF)) perf_stalls_d = perf_stalls_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      perf_bubbles_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      perf_bubbles_q <= perf_bubbles_d;
      perf_stalls_q  <= perf_stalls_d;
    end
  end

  assign perf_bubbles = perf_bubbles_q;
  assign perf_stalls  = perf_stalls_q;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: reset, pass-through, load-use, x0, flush/stall priority.
// Counter checks are compiled in when ID_EX_PERF_EN is defined.
module tb_id_ex_stage;
  import rv_pipe_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_d;
  ctrl_t       ctrl_d;
  logic [31:0] pc_d, pc_plus4_d, rd1_d, rd2_d, imm_d;
  logic [4:0]  rs1_d, rs2_d, rd_d;
  logic        flush_e, stall_e, stall_d;
  logic        valid_e;
  ctrl_t       ctrl_e;
  logic [31:0] pc_e, pc_plus4_e, rd1_e, rd2_e, imm_e;
  logic [4:0]  rs1_e, rs2_e, rd_e;
`ifdef ID_EX_PERF_EN
  logic [31:0] perf_bubbles, perf_stalls;
`endif

  int total = 0;
  int bad   = 0;

  ctrl_t c_add, c_lw;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk(clk), .rst(rst), .valid_d(valid_d), .ctrl_d(ctrl_d),
    .pc_d(pc_d), .pc_plus4_d(pc_plus4_d), .rd1_d(rd1_d), .rd2_d(rd2_d), .imm_d(imm_d),
    .rs1_d(rs1_d), .rs2_d(rs2_d), .rd_d(rd_d),
    .flush_e(flush_e), .stall_e(stall_e), .stall_d(stall_d),
`ifdef ID_EX_PERF_EN
    .perf_bubbles(perf_bubbles), .perf_stalls(perf_stalls),
`endif
    .valid_e(valid_e), .ctrl_e(ctrl_e), .pc_e(pc_e), .pc_plus4_e(pc_plus4_e),
    .rd1_e(rd1_e), .rd2_e(rd2_e), .imm_e(imm_e),
    .rs1_e(rs1_e), .rs2_e(rs2_e), .rd_e(rd_e)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
    $display("check %-14s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input ctrl_t c, input logic [31:0] pc,
                       input logic [31:0] r1, input logic [4:0] s1,
                       input logic [4:0] s2, input logic [4:0] d);
    valid_d    = v;
    ctrl_d     = c;
    pc_d       = pc;
    pc_plus4_d = pc + 32'd4;
    rd1_d      = r1;
    rd2_d      = r1 ^ 32'hFFFF_0000;
    imm_d      = pc ^ 32'h0000_00FF;
    rs1_d      = s1;
    rs2_d      = s2;
    rd_d       = d;
    #1;
  endtask

  initial begin
    c_add = CTRL_NOP;
    c_add.RegWrite = 1'b1;
    c_add.ALUctrl  = 3'b010;
    c_lw = CTRL_NOP;
    c_lw.RegWrite  = 1'b1;
    c_lw.ALUSrc    = 1'b1;
    c_lw.ResultSrc = 2'b01;

    // Reset with arbitrary inputs
    rst = 1'b1; flush_e = 1'b0; stall_e = 1'b0;
    drive(1'b1, ctrl_t'(15'h7FFF), 32'h1234_5678, 32'hCAFE_F00D, 5'd3, 5'd4, 5'd5);
    tick(); tick();
    chk("rst_valid", {31'd0, valid_e}, 32'd0);
    chk("rst_ctrl", {17'd0, ctrl_e}, 32'd0);
    chk("rst_rd1", rd1_e, 32'd0);
    chk("rst_pc", pc_e, 32'd0);
    chk("rst_rd", {27'd0, rd_e}, 32'd0);
    chk("rst_stall_d", {31'd0, stall_d}, 32'd0);

    // Pass-through
    rst = 1'b0;
    drive(1'b1, c_add, 32'h100, 32'hDEAD_BEEF, 5'd1, 5'd2, 5'd7);
    tick();
    chk("pt_valid", {31'd0, valid_e}, 32'd1);
    chk("pt_pc", pc_e, 32'h100);
    chk("pt_rd1", rd1_e, 32'hDEAD_BEEF);
    chk("pt_ctrl", {17'd0, ctrl_e}, {17'd0, c_add});
    chk("pt_rd", {27'd0, rd_e}, 32'd7);
    chk("pt_pc4", pc_plus4_e, 32'h104);

    // Load-use: lw x5 in EX, dependent uses rs2 = x5
    drive(1'b1, c_lw, 32'h104, 32'h0, 5'd1, 5'd2, 5'd5);
    tick();
    drive(1'b1, c_add, 32'h108, 32'hAAAA, 5'd3, 5'd5, 5'd6);
    chk("lu_stall_d", {31'd0, stall_d}, 32'd1);
    tick();
    chk("lu_bub_valid", {31'd0, valid_e}, 32'd0);
    chk("lu_bub_ctrl", {17'd0, ctrl_e}, 32'd0);
    chk("lu_bub_pc", pc_e, 32'h104);
    chk("lu_stall_d2", {31'd0, stall_d}, 32'd0);
    tick();
    chk("lu_dep_valid", {31'd0, valid_e}, 32'd1);
    chk("lu_dep_pc", pc_e, 32'h108);
    chk("lu_dep_rd", {27'd0, rd_e}, 32'd6);

    // x0 destination: never stalls
    drive(1'b1, c_lw, 32'h10C, 32'h0, 5'd1, 5'd2, 5'd0);
    tick();
    drive(1'b1, c_add, 32'h110, 32'h1, 5'd3, 5'd0, 5'd6);
    chk("x0_stall_d", {31'd0, stall_d}, 32'd0);
    tick();
    chk("x0_valid", {31'd0, valid_e}, 32'd1);
    chk("x0_pc", pc_e, 32'h110);

    // Flush wins over stall_e
    drive(1'b1, c_add, 32'h114, 32'h2, 5'd1, 5'd2, 5'd3);
    flush_e = 1'b1; stall_e = 1'b1; #1;
    chk("fs_stall_d", {31'd0, stall_d}, 32'd1);
    tick();
    chk("fs_valid", {31'd0, valid_e}, 32'd0);
    chk("fs_ctrl", {17'd0, ctrl_e}, 32'd0);
    chk("fs_pc_hold", pc_e, 32'h110);

    // Flush suppresses load-use stall
    flush_e = 1'b0; stall_e = 1'b0;
    drive(1'b1, c_lw, 32'h118, 32'h0, 5'd1, 5'd2, 5'd5);
    tick();
    drive(1'b1, c_add, 32'h11C, 32'h3, 5'd5, 5'd2, 5'd4);
    flush_e = 1'b1; #1;
    chk("fl_lu_stall_d", {31'd0, stall_d}, 32'd0);
    tick();
    chk("fl_lu_valid", {31'd0, valid_e}, 32'd0);
    chk("fl_lu_pc", pc_e, 32'h118);

    // stall_e alone for 3 cycles
    flush_e = 1'b0;
    drive(1'b1, c_add, 32'h200, 32'h55, 5'd1, 5'd2, 5'd9);
    tick();
    stall_e = 1'b1;
    drive(1'b1, c_lw, 32'h300, 32'h66, 5'd4, 5'd6, 5'd8);
    for (int i = 0; i < 3; i++) begin
      chk("st_stall_d", {31'd0, stall_d}, 32'd1);
      tick();
      chk("st_valid", {31'd0, valid_e}, 32'd1);
      chk("st_pc", pc_e, 32'h200);
      chk("st_rd1", rd1_e, 32'h55);
    end

    // Load-use together with stall_e: hold, then bubble
    stall_e = 1'b0;
    drive(1'b1, c_lw, 32'h204, 32'h0, 5'd1, 5'd2, 5'd8);
    tick();
    drive(1'b1, c_add, 32'h208, 32'h7, 5'd8, 5'd2, 5'd10);
    stall_e = 1'b1; #1;
    chk("lus_stall_d", {31'd0, stall_d}, 32'd1);
    tick();
    chk("lus_valid", {31'd0, valid_e}, 32'd1);
    chk("lus_pc", pc_e, 32'h204);
    chk("lus_ctrl", {17'd0, ctrl_e}, {17'd0, c_lw});
    chk("lus_stall_d2", {31'd0, stall_d}, 32'd1);
    stall_e = 1'b0; #1;
    chk("lus_stall_d3", {31'd0, stall_d}, 32'd1);
    tick();
    chk("lus_bub_valid", {31'd0, valid_e}, 32'd0);
    chk("lus_stall_d4", {31'd0, stall_d}, 32'd0);
    tick();
    chk("lus_dep_pc", pc_e, 32'h208);

    // valid_d = 0 produces a bubble and holds data
    drive(1'b0, c_add, 32'h400, 32'h9, 5'd1, 5'd2, 5'd3);
    tick();
    chk("vd0_valid", {31'd0, valid_e}, 32'd0);
    chk("vd0_ctrl", {17'd0, ctrl_e}, 32'd0);
    chk("vd0_pc", pc_e, 32'h208);

    // Reset while stalled
    drive(1'b1, c_add, 32'h500, 32'hA, 5'd1, 5'd2, 5'd3);
    tick();
    chk("rs_pre_pc", pc_e, 32'h500);
    stall_e = 1'b1; rst = 1'b1;
    tick();
    rst = 1'b0; #1;
    chk("rs_valid", {31'd0, valid_e}, 32'd0);
    chk("rs_pc", pc_e, 32'd0);
    chk("rs_stall_d", {31'd0, stall_d}, 32'd1);
    stall_e = 1'b0; #1;
    chk("rs_stall_d0", {31'd0, stall_d}, 32'd0);

`ifdef ID_EX_PERF_EN
    rst = 1'b1; tick(); rst = 1'b0;
    chk("pf_rst", perf_bubbles, 32'd0);
    drive(1'b1, c_add, 32'h600, 32'h1, 5'd1, 5'd2, 5'd3);
    flush_e = 1'b1;
    tick(); tick(); tick();
    flush_e = 1'b0;
    for (int k = 0; k < 2; k++) begin
      drive(1'b1, c_lw, 32'h700, 32'h0, 5'd1, 5'd2, 5'd5);
      tick();
      drive(1'b1, c_add, 32'h704, 32'h0, 5'd5, 5'd2, 5'd6);
      tick();
      tick();
    end
    chk("pf_bubbles", perf_bubbles, 32'd5);
    chk("pf_stalls", perf_stalls, 32'd2);
    force dut.perf_bubbles_q = 32'hFFFF_FFFF;
    force dut.perf_stalls_q  = 32'hFFFF_FFFF;
    #1;
    release dut.perf_bubbles_q;
    release dut.perf_stalls_q;
    flush_e = 1'b1; stall_e = 1'b1;
    tick();
    chk("pf_sat_b", perf_bubbles, 32'hFFFF_FFFF);
    chk("pf_sat_s", perf_stalls, 32'hFFFF_FFFF);
    flush_e = 1'b0; stall_e = 1'b0;
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
